// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch-stage next-PC arbiter: sequential fetch, redirects, stalls,
//            imem wait states, parked redirects and permanent halt.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             redirect_valid,
    input  logic [2:0]       redirect_type,
    input  logic [31:0]      redirect_data,
    output logic [2:0]       pc_select,
    output logic [31:0]      jump_data,
    output logic             flush_ifid,
    output logic             imemREN,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] c_sel_next  = 3'd0;
    localparam logic [2:0] c_sel_jump  = 3'd1;
    localparam logic [2:0] c_sel_jr    = 3'd2;
    localparam logic [2:0] c_sel_br    = 3'd3;
    localparam logic [2:0] c_sel_halt  = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PEND   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [2:0]        r_pend_type;
    logic [31:0]       r_pend_data;
    logic [CNT_W-1:0]  r_redirect_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_capture;
    logic              w_applied;
    logic              w_held;
    logic              w_redir_ok;

    // Unknown select codes never redirect; they behave like a plain fetch.
    assign w_redir_ok = redirect_valid &&
                        ((redirect_type == c_sel_jump) ||
                         (redirect_type == c_sel_jr)   ||
                         (redirect_type == c_sel_br));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state        <= ST_RUN;
            r_pend_type    <= 3'd0;
            r_pend_data    <= 32'd0;
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_pend_type <= redirect_type;
                r_pend_data <= redirect_data;
            end else if (w_next_state != ST_PEND) begin
                r_pend_type <= 3'd0;
                r_pend_data <= 32'd0;
            end
            if (w_applied && (r_redirect_cnt != {CNT_W{1'b1}}))
                r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
            if (w_held && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next_state = r_state;
        pc_select    = c_sel_next;
        jump_data    = 32'd0;
        flush_ifid   = 1'b0;
        imemREN      = 1'b1;
        w_capture    = 1'b0;
        w_applied    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (halt_req) begin
                    pc_select    = c_sel_halt;
                    w_next_state = ST_HALTED;
                end else if (w_redir_ok && ihit) begin
                    pc_select  = redirect_type;
                    jump_data  = redirect_data;
                    flush_ifid = 1'b1;
                    w_applied  = 1'b1;
                end else if (w_redir_ok) begin
                    pc_select    = c_sel_halt;
                    flush_ifid   = 1'b1;
                    w_capture    = 1'b1;
                    w_next_state = ST_PEND;
                end else if (stall || !ihit) begin
                    pc_select = c_sel_halt;
                end
            end
            ST_PEND: begin
                // Later redirects come from the squashed path and are dropped.
                if (halt_req) begin
                    pc_select    = c_sel_halt;
                    w_next_state = ST_HALTED;
                end else if (ihit) begin
                    pc_select    = r_pend_type;
                    jump_data    = r_pend_data;
                    flush_ifid   = 1'b1;
                    w_applied    = 1'b1;
                    w_next_state = ST_RUN;
                end else begin
                    pc_select = c_sel_halt;
                end
            end
            ST_HALTED: begin
                pc_select = c_sel_halt;
                imemREN   = 1'b0;
            end
            default: begin
                pc_select    = c_sel_halt;
                w_next_state = ST_RUN;
            end
        endcase
        if (!nRST) begin
            pc_select  = c_sel_halt;
            jump_data  = 32'd0;
            flush_ifid = 1'b0;
            imemREN    = 1'b1;
        end
    end

    assign w_held       = (r_state != ST_HALTED) && (pc_select == c_sel_halt);
    assign halted       = (r_state == ST_HALTED);
    assign redirect_cnt = r_redirect_cnt;
    assign stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage controller that drives the program counter's next-PC select and jump operand every cycle.
- Arbitrates between sequential fetch, control-flow redirects from the execute stage, hazard stalls, instruction-memory wait states and halt.
- Parks a redirect that arrives while instruction memory is busy and applies it once memory accepts.
- Sits between hazard unit / execute stage and the PC register; also drives the IF/ID flush and the fetch read-enable.

Parameters:
- CNT_W, 16, width of the saturating performance counters.

Ports:
- CLK  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- ihit  input  1  instruction memory returned the current fetch this cycle
- stall  input  1  hazard unit requests the PC hold
- halt_req  input  1  halt instruction has reached decode
- redirect_valid  input  1  execute stage resolved a taken control transfer
- redirect_type  input  3  select code for the redirect: JUMP=1, JUMPREGISTER=2, BRANCH=3
- redirect_data  input  32  jump target field, register value or branch immediate
- pc_select  output  3  NEXT=0, JUMP=1, JUMPREGISTER=2, BRANCH=3, HALT=4 (hold)
- jump_data  output  32  operand accompanying pc_select
- flush_ifid  output  1  squash the instruction in IF/ID
- imemREN  output  1  instruction read enable
- halted  output  1  sequencer permanently halted
- redirect_cnt  output  CNT_W  applied redirects, saturating
- stall_cnt  output  CNT_W  cycles the PC was held while in RUN or PEND, saturating

Behaviour:
- Interface: one clock, CLK. Reset nRST is asynchronous and active-low.
- Reset values:
  - state=RUN, pending registers cleared, halted=0, both counters 0.
  - Combinational outputs under reset: pc_select=HALT, flush_ifid=0, jump_data=0, imemREN=1.
- Outputs are combinational from state plus inputs. Next-PC takes effect at the following CLK edge, so latency is 0 cycles from input to select.
- States: RUN, PEND, HALTED.
- RUN, in priority order:
  1. halt_req=1 -> pc_select=HALT, flush_ifid=0; next state HALTED. Any concurrent redirect is discarded.
  2. redirect_valid & ihit -> pc_select=redirect_type, jump_data=redirect_data, flush_ifid=1; redirect_cnt++. Redirect overrides stall.
  3. redirect_valid & !ihit -> capture type/data into pending regs, pc_select=HALT, flush_ifid=1; next state PEND.
  4. stall | !ihit -> pc_select=HALT.
  5. otherwise -> pc_select=NEXT, jump_data=0.
- PEND:
  - pc_select=HALT until ihit=1.
  - On ihit: pc_select=pending type, jump_data=pending data, flush_ifid=1; redirect_cnt++; next state RUN.
  - stall is ignored on that cycle.
  - redirect_valid while in PEND is ignored: the first redirect wins, because later ones come from the squashed path.
  - halt_req while in PEND -> HALTED; pending discarded and not counted.
- HALTED:
  - pc_select=HALT, imemREN=0, halted=1, flush_ifid=0.
  - All inputs ignored; exit only through nRST.
- Counters:
  - stall_cnt increments in each RUN/PEND cycle where pc_select=HALT.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- Invalid redirect_type (0, 4-7) with redirect_valid is treated as NEXT: no flush, no count, no PEND entry.
- Reset asserted mid-PEND or in HALTED returns to the reset values immediately, without waiting for CLK.

Test Plan:
- Sequential: ihit=1 for 5 cycles, no other inputs -> pc_select=0 each cycle, stall_cnt=0, imemREN=1.
- Branch with hit: redirect_valid=1, type=3, data=32'h0000FFFC, ihit=1, stall=1 -> same cycle pc_select=3, jump_data=32'h0000FFFC, flush_ifid=1; redirect_cnt=1.
- Branch during memory wait: redirect type=2, data=32'h00400020, ihit=0 for 3 cycles, then 1; a second redirect (type=1) in cycle 2 -> pc_select=4 for 3 cycles, then 2 with jump_data=32'h00400020; the second redirect is ignored; redirect_cnt=1, stall_cnt=3.
- Halt priority: halt_req=1 with redirect_valid=1 -> pc_select=4, halted=1 next cycle, imemREN=0; redirect_cnt unchanged; later redirects have no effect.
- Reset mid-PEND: enter PEND, assert nRST=0 between edges -> halted=0 and counters 0 immediately; after release, pc_select=0 with ihit=1 and no pending redirect applied.
- Saturation with CNT_W=4: stall=1 for 20 cycles -> stall_cnt stops at 15.
